timing_gen: RTL
===============

TIMING_GEN -- requirements
Module: timing_gen

Interface
REQ-001 Parameter CNT_W, default 16, width of all counters and timing fields.
REQ-002 Parameter NUM_WIN, default 2, number of independent read windows (1..8).
REQ-003 Parameter PIPE_DLY, default 2, output pipeline depth in cycles (1..4).
REQ-004 I_pxl_clk  input  1  pixel clock; all logic on rising edge.
REQ-005 I_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 I_en  input  1  run enable; low holds the timing engine idle.
REQ-007 I_h_total, I_h_sync, I_h_bporch, I_h_res  input  CNT_W each  horizontal timing in pixels.
REQ-008 I_v_total, I_v_sync, I_v_bporch, I_v_res  input  CNT_W each  vertical timing in lines.
REQ-009 I_hs_pol, I_vs_pol  input  1 each  sync polarity; 1 = active-high pulse, 0 = active-low pulse.
REQ-010 I_win_x, I_win_y, I_win_w, I_win_h  input  NUM_WIN*CNT_W each  window i origin/size at slice [i*CNT_W +: CNT_W], relative to active-area origin.
REQ-011 O_de, O_hs, O_vs  output  1 each  delayed data enable and syncs.
REQ-012 O_win_en  output  NUM_WIN  per-window read enable.
REQ-013 O_sof, O_sol  output  1 each  one-cycle start-of-frame / start-of-active-line pulses.
REQ-014 O_act_x, O_act_y  output  CNT_W each  active-area pixel coordinates, valid when O_de=1.
REQ-015 H_cnt, V_cnt  output  CNT_W each  raw counters, undelayed.

Function
REQ-016 All timing and window inputs SHALL be captured into shadow registers every cycle while I_en=0, and while I_en=1 only on the cycle H_cnt=h_total-1 and V_cnt=v_total-1; logic SHALL use shadow values only.
REQ-017 With I_en=1, H_cnt SHALL increment each cycle and wrap to 0 when H_cnt >= h_total-1; V_cnt SHALL increment on each H wrap and wrap to 0 when also V_cnt >= v_total-1.
REQ-018 With I_en=0, H_cnt and V_cnt SHALL be forced to 0 and all delayed outputs SHALL take their reset values PIPE_DLY cycles later.
REQ-019 h_total or v_total of 0 or 1 SHALL hold that counter at 0, with no X or overflow.
REQ-020 Undelayed de SHALL be 1 when h_sync+h_bporch <= H_cnt < h_sync+h_bporch+h_res and v_sync+v_bporch <= V_cnt < v_sync+v_bporch+v_res.
REQ-021 Undelayed hs SHALL be active while H_cnt < h_sync; undelayed vs SHALL be active while V_cnt < v_sync; a sync width of 0 SHALL give no pulse.
REQ-022 Window i SHALL be active when de=1, x <= H_cnt-(h_sync+h_bporch) < x+w and y <= V_cnt-(v_sync+v_bporch) < y+h; w=0 or h=0 SHALL disable that window.
REQ-023 Window bounds extending past h_res/v_res SHALL be clipped by de.
REQ-024 Undelayed sof SHALL be 1 at H_cnt=0, V_cnt=0; undelayed sol SHALL be 1 on the first de cycle of each line.
REQ-025 act_x/act_y SHALL be H_cnt/V_cnt minus the respective sync+bporch; they SHALL read 0 when de=0.
REQ-026 All range sums and comparisons SHALL use CNT_W+1 bits; no wrap-around of sums.
REQ-027 O_de, O_hs, O_vs, O_win_en, O_sof, O_sol, O_act_x, O_act_y SHALL all lag H_cnt/V_cnt by exactly PIPE_DLY cycles and remain mutually aligned.
REQ-028 Polarity SHALL be applied at the final pipeline stage from the live I_hs_pol/I_vs_pol.

Reset
REQ-029 On I_rst_n=0, asynchronously: H_cnt=0, V_cnt=0, shadows=0, all pipeline stages de=0, win_en=0, sof=0, sol=0, act=0, internal hs/vs inactive.
REQ-030 During reset O_hs=~I_hs_pol and O_vs=~I_vs_pol (inactive level); reset mid-frame SHALL restart from H_cnt=0, V_cnt=0 on the first clock after release.

Verification
REQ-031 h_total=10, h_sync=2, h_bp=1, h_res=5, v_total=6, v_sync=1, v_bp=1, v_res=3, PIPE_DLY=2 -> O_de high for 5 cycles starting 2 cycles after H_cnt=3 on V_cnt=2,3,4; 15 de cycles per frame.
REQ-032 Same timing, hs_pol=0 -> O_hs low for 2 cycles per line; hs_pol=1 -> high for 2 cycles; O_sof once per 60 cycles.
REQ-033 Window 0 x=1, y=1, w=2, h=1 -> O_win_en[0] high exactly at act_x=1,2 on act_y=1; window 1 w=0 -> never high.
REQ-034 Change h_res from 5 to 4 mid-frame -> old value used until frame wrap; new width from next frame's first line.
REQ-035 Window x=3, w=10 with h_res=5 -> O_win_en high only at act_x=3,4.
REQ-036 Assert I_rst_n=0 at H_cnt=7, V_cnt=3 -> all outputs at reset values immediately; after release H_cnt counts 0,1,2.

Source files
------------

// File: rtl/timing_gen.sv
// timing_gen: video timing engine.
//   Free-running H/V counters on I_pxl_clk generate data enable, syncs,
//   start-of-frame / start-of-line pulses, active-area coordinates and
//   NUM_WIN rectangular read-window enables. Timing and window settings
//   come from shadow registers. The shadows reload on every cycle while
//   idle, and only on the last cycle of a frame while running. This lets
//   software change settings at any time without tearing a frame.
// Ports:
//   I_pxl_clk, I_rst_n (async, active-low), I_en (run enable)
//   I_h_* / I_v_*      horizontal (pixels) / vertical (lines) timing
//   I_hs_pol/I_vs_pol  sync polarity, 1 = active-high pulse
//   I_win_x/y/w/h      window i at slice [i*CNT_W +: CNT_W]
//   O_de, O_hs, O_vs, O_win_en, O_sof, O_sol, O_act_x, O_act_y
//                      all delayed by PIPE_DLY cycles and mutually aligned
//   H_cnt, V_cnt       raw counters, not delayed

// One read window: active inside [x, x+w) x [y, y+h) of the active area.
module timing_gen_win #(
  parameter int CNT_W = 16
) (
  input  logic             de,
  input  logic [CNT_W-1:0] ax,
  input  logic [CNT_W-1:0] ay,
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  logic [CNT_W-1:0] w,
  input  logic [CNT_W-1:0] h,
  output logic             en
);
  localparam int XW = CNT_W + 1;

  // The extra bit keeps x+w from wrapping. w=0 or h=0 gives an empty range.
  assign en = de &&
              (ax >= x) && (XW'(ax) < XW'(x) + XW'(w)) &&
              (ay >= y) && (XW'(ay) < XW'(y) + XW'(h));
endmodule

module timing_gen #(
  parameter int CNT_W    = 16,
  parameter int NUM_WIN  = 2,
  parameter int PIPE_DLY = 2
) (
  input  logic                     I_pxl_clk,
  input  logic                     I_rst_n,
  input  logic                     I_en,
  input  logic [CNT_W-1:0]         I_h_total,
  input  logic [CNT_W-1:0]         I_h_sync,
  input  logic [CNT_W-1:0]         I_h_bporch,
  input  logic [CNT_W-1:0]         I_h_res,
  input  logic [CNT_W-1:0]         I_v_total,
  input  logic [CNT_W-1:0]         I_v_sync,
  input  logic [CNT_W-1:0]         I_v_bporch,
  input  logic [CNT_W-1:0]         I_v_res,
  input  logic                     I_hs_pol,
  input  logic                     I_vs_pol,
  input  logic [NUM_WIN*CNT_W-1:0] I_win_x,
  input  logic [NUM_WIN*CNT_W-1:0] I_win_y,
  input  logic [NUM_WIN*CNT_W-1:0] I_win_w,
  input  logic [NUM_WIN*CNT_W-1:0] I_win_h,
  output logic                     O_de,
  output logic                     O_hs,
  output logic                     O_vs,
  output logic [NUM_WIN-1:0]       O_win_en,
  output logic                     O_sof,
  output logic                     O_sol,
  output logic [CNT_W-1:0]         O_act_x,
  output logic [CNT_W-1:0]         O_act_y,
  output logic [CNT_W-1:0]         H_cnt,
  output logic [CNT_W-1:0]         V_cnt
);
  // sync+bporch+res is a three-term sum. Two extra bits mean it never wraps.
  localparam int EW = CNT_W + 2;

  typedef struct packed {
    logic [CNT_W-1:0]         h_tot, h_syn, h_bp, h_res;
    logic [CNT_W-1:0]         v_tot, v_syn, v_bp, v_res;
    logic [NUM_WIN*CNT_W-1:0] wx, wy, ww, wh;
  } shd_t;

  typedef struct packed {
    logic               de, hs, vs, sof, sol;
    logic [NUM_WIN-1:0] win;
    logic [CNT_W-1:0]   ax, ay;
  } stg_t;

  shd_t             shd_q, shd_d, shd_live;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic             h_last, v_last;

  assign shd_live = '{h_tot: I_h_total, h_syn: I_h_sync, h_bp: I_h_bporch,
                      h_res: I_h_res, v_tot: I_v_total, v_syn: I_v_sync,
                      v_bp: I_v_bporch, v_res: I_v_res, wx: I_win_x,
                      wy: I_win_y, ww: I_win_w, wh: I_win_h};

  // A total of 0 or 1 makes every cycle a "last" cycle. This pins that
  // counter at 0, and the subtraction is never reached for those values.
  assign h_last = (shd_q.h_tot <= CNT_W'(1)) ||
                  (h_cnt_q >= shd_q.h_tot - CNT_W'(1));
  assign v_last = (shd_q.v_tot <= CNT_W'(1)) ||
                  (v_cnt_q >= shd_q.v_tot - CNT_W'(1));

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    shd_d   = shd_q;
    if (!I_en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
      shd_d   = shd_live;
    end else begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
      // Reload at the frame boundary so that new settings start cleanly.
      if (h_last && v_last) shd_d = shd_live;
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      shd_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      shd_q   <= shd_d;
    end
  end

  assign H_cnt = h_cnt_q;
  assign V_cnt = v_cnt_q;

  // ---- undelayed decode (stage 0) ----
  logic [EW-1:0]      hc, vc, h_st, v_st, h_end, v_end;
  logic               de0;
  logic [CNT_W-1:0]   ax0, ay0;
  logic [NUM_WIN-1:0] win0;
  stg_t               stg0;

  assign hc    = EW'(h_cnt_q);
  assign vc    = EW'(v_cnt_q);
  assign h_st  = EW'(shd_q.h_syn) + EW'(shd_q.h_bp);
  assign v_st  = EW'(shd_q.v_syn) + EW'(shd_q.v_bp);
  assign h_end = h_st + EW'(shd_q.h_res);
  assign v_end = v_st + EW'(shd_q.v_res);
  assign de0   = (hc >= h_st) && (hc < h_end) && (vc >= v_st) && (vc < v_end);
  // When de0 is set, hc >= h_st, so the difference always fits in CNT_W.
  assign ax0   = de0 ? CNT_W'(hc - h_st) : '0;
  assign ay0   = de0 ? CNT_W'(vc - v_st) : '0;

  for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
    timing_gen_win #(.CNT_W(CNT_W)) u_win (
      .de (de0),
      .ax (ax0),
      .ay (ay0),
      .x  (shd_q.wx[i*CNT_W +: CNT_W]),
      .y  (shd_q.wy[i*CNT_W +: CNT_W]),
      .w  (shd_q.ww[i*CNT_W +: CNT_W]),
      .h  (shd_q.wh[i*CNT_W +: CNT_W]),
      .en (win0[i])
    );
  end

  // When idle, feed reset values into the pipe. The outputs then reach
  // their idle state exactly PIPE_DLY cycles after I_en drops.
  always_comb begin
    stg0 = '0;
    if (I_en) begin
      stg0.de  = de0;
      stg0.hs  = h_cnt_q < shd_q.h_syn;
      stg0.vs  = v_cnt_q < shd_q.v_syn;
      stg0.sof = (h_cnt_q == '0) && (v_cnt_q == '0);
      stg0.sol = de0 && (hc == h_st);
      stg0.win = win0;
      stg0.ax  = ax0;
      stg0.ay  = ay0;
    end
  end

  // ---- output delay line ----
  stg_t [PIPE_DLY:1] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[1] = stg0;
    for (int i = 2; i <= PIPE_DLY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) pipe_q <= '0;
    else          pipe_q <= pipe_d;
  end

  assign O_de     = pipe_q[PIPE_DLY].de;
  assign O_win_en = pipe_q[PIPE_DLY].win;
  assign O_sof    = pipe_q[PIPE_DLY].sof;
  assign O_sol    = pipe_q[PIPE_DLY].sol;
  assign O_act_x  = pipe_q[PIPE_DLY].ax;
  assign O_act_y  = pipe_q[PIPE_DLY].ay;
  // Polarity is applied last, from the live pins. The pipe carries "active".
  assign O_hs     = pipe_q[PIPE_DLY].hs ? I_hs_pol : ~I_hs_pol;
  assign O_vs     = pipe_q[PIPE_DLY].vs ? I_vs_pol : ~I_vs_pol;
endmodule
